// File: rtl/htif_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// htif_pkg -- shared state type, default addresses and helpers for the HTIF
// tohost/fromhost responder.                                       rev 1.0
// ---------------------------------------------------------------------------
package htif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_BUSY     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_HALT     = 3'd4
  } htif_state_e;

  localparam logic [31:0] TOHOST_ADDR_DEF   = 32'h0000_1000;
  localparam logic [31:0] FROMHOST_ADDR_DEF = 32'h0000_1040;
  localparam logic [31:0] PASS_VALUE        = 32'h1;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_val,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/htif_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// htif_watchdog -- saturating cycle counter with enable, clear and expire
// flag; LIMIT of 0 disables expiry.                                rev 1.0
// ---------------------------------------------------------------------------
module htif_watchdog #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LIMIT = 6000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam logic [WIDTH-1:0] c_max   = '1;
  localparam logic [WIDTH-1:0] c_limit = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != c_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (LIMIT != 0) && (r_count >= c_limit);

endmodule
`default_nettype wire

// File: rtl/htif_tohost_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// htif_tohost_responder -- tohost/fromhost bus responder that decodes the
// riscv-tests verdict, answers syscalls and runs a cycle watchdog.  rev 1.0
// ---------------------------------------------------------------------------
module htif_tohost_responder
  import htif_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR   = TOHOST_ADDR_DEF,
  parameter logic [31:0] FROMHOST_ADDR = FROMHOST_ADDR_DEF,
  parameter int unsigned TIMEOUT       = 6000,
  parameter int unsigned ACK_DELAY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic        bus_hit,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic        timeout
);

  // The BUSY cycle that sees a zero count is itself the last delay cycle.
  localparam logic [31:0] c_ack_load = (ACK_DELAY > 1) ? 32'(ACK_DELAY - 1) : 32'd0;

  htif_state_e r_state, w_state_nx;
  logic [31:0] r_tohost, w_tohost_nx;
  logic [31:0] r_fromhost, w_fromhost_nx;
  logic [31:0] r_dly, w_dly_nx;
  logic        r_done, w_done_nx;
  logic        r_pass, w_pass_nx;
  logic        r_timeout, w_timeout_nx;
  logic [30:0] r_fail, w_fail_nx;

  logic        w_to_sel, w_from_sel, w_wr_to, w_wr_from, w_expire, w_unused;
  logic [31:0] w_to_merged, w_from_merged, w_v;

  assign w_to_sel      = bus_valid && (bus_addr[31:2] == TOHOST_ADDR[31:2]);
  assign w_from_sel    = bus_valid && (bus_addr[31:2] == FROMHOST_ADDR[31:2]);
  assign bus_hit       = w_to_sel || w_from_sel;
  assign bus_ready     = bus_hit && (r_state != ST_BUSY);
  assign w_wr_to       = bus_ready && bus_we && w_to_sel;
  assign w_wr_from     = bus_ready && bus_we && w_from_sel && !w_to_sel;
  assign w_to_merged   = byte_merge(r_tohost, bus_wdata, bus_wstrb);
  assign w_from_merged = byte_merge(r_fromhost, bus_wdata, bus_wstrb);
  assign w_v           = w_wr_to ? w_to_merged : r_tohost;
  assign bus_rdata     = (bus_hit && !bus_we) ? (w_to_sel ? r_tohost : r_fromhost) : 32'd0;
  assign w_unused      = ^bus_addr[1:0];

  htif_watchdog #(
    .WIDTH (32),
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_state != ST_HALT),
    .i_clr    (1'b0),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_tohost_nx   = r_tohost;
    w_fromhost_nx = r_fromhost;
    w_dly_nx      = r_dly;
    w_done_nx     = r_done;
    w_pass_nx     = r_pass;
    w_fail_nx     = r_fail;
    w_timeout_nx  = r_timeout;

    if (w_wr_to)   w_tohost_nx   = w_to_merged;
    if (w_wr_from) w_fromhost_nx = w_from_merged;

    case (r_state)
      ST_IDLE: w_state_nx = ST_RUN;
      // A tohost value stored while not in RUN is still held and decodes here.
      ST_RUN: begin
        if (w_v == PASS_VALUE) begin
          w_pass_nx  = 1'b1;
          w_done_nx  = 1'b1;
          w_state_nx = ST_HALT;
        end else if (w_v[0]) begin
          w_fail_nx  = w_v[31:1];
          w_done_nx  = 1'b1;
          w_state_nx = ST_HALT;
        end else if (w_v != 32'd0) begin
          w_dly_nx   = c_ack_load;
          w_state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_dly == 32'd0) begin
          w_fromhost_nx = 32'd1;
          w_tohost_nx   = 32'd0;
          w_state_nx    = ST_WAIT_ACK;
        end else begin
          w_dly_nx = r_dly - 32'd1;
        end
      end
      ST_WAIT_ACK: begin
        if (w_wr_from && (w_from_merged == 32'd0)) w_state_nx = ST_RUN;
      end
      ST_HALT: w_state_nx = ST_HALT;
      default: w_state_nx = ST_IDLE;
    endcase

    // A verdict taken this cycle has already moved to HALT and wins over expiry.
    if ((r_state != ST_HALT) && (w_state_nx != ST_HALT) && w_expire) begin
      w_timeout_nx = 1'b1;
      w_done_nx    = 1'b1;
      w_state_nx   = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_tohost   <= 32'd0;
      r_fromhost <= 32'd0;
      r_dly      <= 32'd0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 31'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_tohost   <= w_tohost_nx;
      r_fromhost <= w_fromhost_nx;
      r_dly      <= w_dly_nx;
      r_done     <= w_done_nx;
      r_pass     <= w_pass_nx;
      r_fail     <= w_fail_nx;
      r_timeout  <= w_timeout_nx;
    end
  end

  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_code = r_fail;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire
